mem_write_tracer: RTL and testbench
===================================

MEM_WRITE_TRACER -- requirements
Module: mem_write_tracer

Interface
REQ-001 Parameter DEPTH, 16, FIFO entries; SHALL be a power of two, 4..256.
REQ-002 Parameter SEQ_W, 16, sequence-number width in bits.
REQ-003 Port clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port trace_enable  input  1  capture enable.
REQ-006 Port addr_to_mem  input  [0:31]  processor data-memory address, tapped from the processor-to-dmem bus.
REQ-007 Port data_to_mem  input  [0:31]  processor store data.
REQ-008 Port write_enable_to_mem  input  1  processor store strobe.
REQ-009 Port byte_to_mem  input  1  byte-size store.
REQ-010 Port half_word_to_mem  input  1  half-word-size store.
REQ-011 Port trace_valid  output  1  FIFO head entry is valid.
REQ-012 Port trace_ready  input  1  consumer accepts the head entry.
REQ-013 Port trace_addr  output  [0:31]  head entry address.
REQ-014 Port trace_data  output  [0:31]  head entry store data, raw as driven by the processor.
REQ-015 Port trace_size  output  [0:1]  head entry size: 00 word, 01 byte, 10 half-word.
REQ-016 Port trace_seq  output  [0:SEQ_W-1]  head entry sequence number.
REQ-017 Port drop_count  output  [0:15]  stores lost to overflow.
REQ-018 Port fill_level  output  [0:log2(DEPTH)]  current FIFO occupancy.

Function
REQ-019 The block SHALL be passive: it only observes the processor/dmem bus and drives nothing onto it.
REQ-020 Registers prev_we, prev_addr and prev_data SHALL track the bus every cycle, regardless of trace_enable.
REQ-021 A store event SHALL be detected when write_enable_to_mem=1 and either prev_we=0, or addr_to_mem!=prev_addr, or data_to_mem!=prev_data.
REQ-022 A detected event SHALL be ignored when trace_enable=0; it SHALL then consume no sequence number and cause no drop.
REQ-023 Size encoding: byte_to_mem=1 gives 01; otherwise half_word_to_mem=1 gives 10; otherwise 00. byte_to_mem SHALL win if both are 1.
REQ-024 Every enabled event SHALL receive the current sequence counter value; the counter SHALL then increment and wrap modulo 2^SEQ_W.
REQ-025 Latency: an event detected in cycle N SHALL appear at the FIFO head with trace_valid=1 in cycle N+1 when the FIFO was empty.
REQ-026 The FIFO SHALL be show-ahead: trace_valid=(fill_level!=0), with trace_addr, trace_data, trace_size and trace_seq presenting the head entry.
REQ-027 A pop SHALL occur when trace_valid=1 and trace_ready=1 at a clock edge; trace_ready while empty SHALL have no effect.
REQ-028 Full, event, no pop: the entry SHALL be dropped, drop_count SHALL increment and saturate at 0xFFFF, and the sequence number SHALL still advance so the consumer sees a gap.
REQ-029 Full, event, and pop in the same cycle: the push SHALL be accepted, nothing is dropped, and fill_level SHALL stay DEPTH.
REQ-030 Empty, event, and trace_ready=1: the entry SHALL NOT bypass the FIFO; it SHALL be pushed and be poppable from cycle N+1.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; fill_level SHALL range 0..DEPTH.
REQ-032 Head outputs SHALL hold stable while trace_valid=1 and trace_ready=0.

Reset
REQ-033 Reset SHALL clear: fill_level=0, trace_valid=0, pointers=0, sequence counter=0, drop_count=0, prev_we=0, prev_addr=0, prev_data=0.
REQ-034 While reset=1, trace_addr, trace_data, trace_size and trace_seq SHALL read 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries in the same edge; no event SHALL be captured in a cycle where reset=1.
REQ-036 FIFO storage arrays need no reset; only pointers and control state are reset.

Structure
REQ-037 Size encodings (00/01/10) and the entry-width constant SHALL live in a shared trace definitions package/header.
REQ-038 The FIFO SHALL be a sub-module named trace_fifo (show-ahead, DEPTH parameter, push/pop/full/empty/level); detection, sequencing and drop accounting SHALL stay in mem_write_tracer.
REQ-039 Target size is 120-400 lines of RTL in total.

Verification
REQ-040 Single store: addr 0x00002028, data 0x0000000A, write_enable pulsed for 1 cycle -> next cycle trace_valid=1, addr 0x00002028, data 0x0A, size 00, seq 0.
REQ-041 Held strobe: write_enable high for 3 cycles with constant addr/data -> exactly one entry; changing addr on the 2nd cycle -> two entries, seq 0 then 1.
REQ-042 Overflow: DEPTH=4, trace_ready=0, 6 distinct stores -> fill_level=4, drop_count=2; draining yields seq 0,1,2,3.
REQ-043 Full with simultaneous event and pop -> no drop, fill_level stays 4, new entry appears last with the next sequence number.
REQ-044 Size priority: byte=1 and half=1 -> size 01; half only -> 10; trace_enable=0 during a store -> no entry and seq unchanged.
REQ-045 Reset mid-run with 3 entries queued -> next cycle trace_valid=0, fill_level=0, drop_count=0; the next store gets seq 0.

Source files
------------

// File: rtl/mem_write_tracer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_write_tracer_pkg
// Brief  : Shared trace entry definitions (size encodings, entry width).
// Rev    : 1.0
// ============================================================================
package mem_write_tracer_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    // Address + data + size; the sequence number is appended per instance.
    localparam int ENTRY_W = 32 + 32 + 2;

    function automatic logic [1:0] size_encode(input logic byte_sel, input logic half_sel);
        if (byte_sel)
            return SIZE_BYTE;
        else if (half_sel)
            return SIZE_HALF;
        else
            return SIZE_WORD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_write_tracer_fifo.sv
`default_nettype none
// ============================================================================
// Module : trace_fifo
// Brief  : Show-ahead FIFO; a push is accepted when full if a pop coincides.
// Rev    : 1.0
// ============================================================================
module trace_fifo
    import mem_write_tracer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wptr_q <= wptr_q + AW'(1);
            if (do_pop)
                rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_write_tracer.sv
`default_nettype none
// ============================================================================
// Module : mem_write_tracer
// Brief  : Passive store tap; sequences processor stores into a trace FIFO.
// Rev    : 1.0
// ============================================================================
module mem_write_tracer
    import mem_write_tracer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trace_enable,
    input  logic [0:31]             addr_to_mem,
    input  logic [0:31]             data_to_mem,
    input  logic                    write_enable_to_mem,
    input  logic                    byte_to_mem,
    input  logic                    half_word_to_mem,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [0:31]             trace_addr,
    output logic [0:31]             trace_data,
    output logic [0:1]              trace_size,
    output logic [0:SEQ_W-1]        trace_seq,
    output logic [0:15]             drop_count,
    output logic [0:$clog2(DEPTH)]  fill_level
);

    localparam int FW = ENTRY_W + SEQ_W;

    logic             prev_we_q;
    logic [0:31]      prev_addr_q;
    logic [0:31]      prev_data_q;
    logic [SEQ_W-1:0] seq_q,  seq_d;
    logic [15:0]      drop_q, drop_d;

    logic             store_evt;
    logic             capture;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    wentry;
    logic [FW-1:0]    rentry;

    // A held strobe repeats the same store; only new strobes or changed bus values count.
    assign store_evt = write_enable_to_mem &&
                       (!prev_we_q || (addr_to_mem != prev_addr_q) || (data_to_mem != prev_data_q));
    assign capture   = store_evt && trace_enable;
    assign pop       = trace_ready && !fifo_empty;
    assign push      = capture;

    assign wentry = {addr_to_mem, data_to_mem,
                     size_encode(byte_to_mem, half_word_to_mem), seq_q};

    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        if (capture) begin
            seq_d = seq_q + SEQ_W'(1);
            if (fifo_full && !pop && (drop_q != 16'hFFFF))
                drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_we_q   <= 1'b0;
            prev_addr_q <= '0;
            prev_data_q <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
        end else begin
            prev_we_q   <= write_enable_to_mem;
            prev_addr_q <= addr_to_mem;
            prev_data_q <= data_to_mem;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rentry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fill_level)
    );

    assign trace_valid = !fifo_empty;
    assign drop_count  = drop_q;

    // Head fields read as zero while reset is held, independent of stale storage.
    assign trace_addr = reset ? '0 : rentry[SEQ_W+34 +: 32];
    assign trace_data = reset ? '0 : rentry[SEQ_W+2  +: 32];
    assign trace_size = reset ? '0 : rentry[SEQ_W    +: 2];
    assign trace_seq  = reset ? '0 : rentry[0        +: SEQ_W];

endmodule
`default_nettype wire

// File: tb/tb_mem_write_tracer.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_write_tracer
// Brief  : Directed self-checking bench for mem_write_tracer (DEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_mem_write_tracer;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          trace_enable;
    logic [0:31]   addr_to_mem;
    logic [0:31]   data_to_mem;
    logic          write_enable_to_mem;
    logic          byte_to_mem;
    logic          half_word_to_mem;
    logic          trace_valid;
    logic          trace_ready;
    logic [0:31]   trace_addr;
    logic [0:31]   trace_data;
    logic [0:1]    trace_size;
    logic [0:SEQ_W-1] trace_seq;
    logic [0:15]   drop_count;
    logic [0:2]    fill_level;

    int n_checks = 0;
    int n_errors = 0;

    mem_write_tracer #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .trace_enable        (trace_enable),
        .addr_to_mem         (addr_to_mem),
        .data_to_mem         (data_to_mem),
        .write_enable_to_mem (write_enable_to_mem),
        .byte_to_mem         (byte_to_mem),
        .half_word_to_mem    (half_word_to_mem),
        .trace_valid         (trace_valid),
        .trace_ready         (trace_ready),
        .trace_addr          (trace_addr),
        .trace_data          (trace_data),
        .trace_size          (trace_size),
        .trace_seq           (trace_seq),
        .drop_count          (drop_count),
        .fill_level          (fill_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
        write_enable_to_mem = 1'b1;
        addr_to_mem         = a;
        data_to_mem         = d;
        byte_to_mem         = b;
        half_word_to_mem    = h;
        tick();
    endtask

    task automatic idle();
        write_enable_to_mem = 1'b0;
        byte_to_mem         = 1'b0;
        half_word_to_mem    = 1'b0;
    endtask

    task automatic pop_one();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        trace_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        trace_enable = 1'b1;
        trace_ready  = 1'b0;
        addr_to_mem  = '0;
        data_to_mem  = '0;
        idle();
        tick();
        tick();

        // Reset state, sampled while reset is still held
        check("rst_valid", trace_valid, 0);
        check("rst_fill",  fill_level,  0);
        check("rst_drop",  drop_count,  0);
        check("rst_addr",  trace_addr,  0);
        check("rst_seq",   trace_seq,   0);
        reset = 1'b0;

        // Single store, one-cycle latency
        store(32'h0000_2028, 32'h0000_000A, 1'b0, 1'b0);
        idle();
        check("single_valid", trace_valid, 1);
        check("single_addr",  trace_addr,  32'h0000_2028);
        check("single_data",  trace_data,  32'h0000_000A);
        check("single_size",  trace_size,  2'b00);
        check("single_seq",   trace_seq,   0);
        pop_one();
        check("single_popped", trace_valid, 0);

        // Held strobe with constant bus gives one entry
        do_reset();
        store(32'h100, 32'h55, 1'b0, 1'b0);
        store(32'h100, 32'h55, 1'b0, 1'b0);
        store(32'h100, 32'h55, 1'b0, 1'b0);
        idle();
        check("held_fill", fill_level, 1);
        check("held_seq",  trace_seq,  0);

        // Held strobe with address change gives two entries
        do_reset();
        store(32'h200, 32'h1, 1'b0, 1'b0);
        store(32'h204, 32'h1, 1'b0, 1'b0);
        store(32'h204, 32'h1, 1'b0, 1'b0);
        idle();
        check("chg_fill",  fill_level, 2);
        check("chg_seq0",  trace_seq,  0);
        pop_one();
        check("chg_seq1",  trace_seq,  1);
        check("chg_addr1", trace_addr, 32'h204);
        pop_one();

        // Overflow: 6 stores into 4 entries
        do_reset();
        for (int i = 0; i < 6; i++)
            store(32'h1000 + 32'(4*i), 32'(i+1), 1'b0, 1'b0);
        idle();
        check("ovf_fill", fill_level, 4);
        check("ovf_drop", drop_count, 2);
        tick();
        tick();
        check("ovf_hold_addr", trace_addr, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_seq",  trace_seq,  64'(i));
            check("ovf_drain_addr", trace_addr, 64'(32'h1000 + 4*i));
            pop_one();
        end
        check("ovf_empty", trace_valid, 0);
        store(32'h3000, 32'h7, 1'b0, 1'b0);
        idle();
        check("ovf_gap_seq", trace_seq, 6);
        pop_one();

        // Full with simultaneous event and pop
        do_reset();
        check("rst_drop_clr", drop_count, 0);
        for (int i = 0; i < 4; i++)
            store(32'h2000 + 32'(4*i), 32'h10 + 32'(i), 1'b0, 1'b0);
        trace_ready = 1'b1;
        store(32'h2FF0, 32'hBEEF, 1'b0, 1'b0);
        trace_ready = 1'b0;
        idle();
        check("fp_fill", fill_level, 4);
        check("fp_drop", drop_count, 0);
        for (int i = 0; i < 4; i++) begin
            check("fp_seq", trace_seq, 64'(i+1));
            if (i == 3) begin
                check("fp_last_addr", trace_addr, 32'h2FF0);
                check("fp_last_data", trace_data, 32'hBEEF);
            end
            pop_one();
        end
        check("fp_empty", fill_level, 0);

        // Empty with event and ready: no bypass
        do_reset();
        trace_ready = 1'b1;
        store(32'h4000, 32'h44, 1'b0, 1'b0);
        idle();
        check("nb_valid", trace_valid, 1);
        check("nb_fill",  fill_level,  1);
        tick();
        trace_ready = 1'b0;
        check("nb_popped", fill_level, 0);

        // Size priority and trace_enable gating
        do_reset();
        store(32'h5000, 32'h1, 1'b1, 1'b1);
        store(32'h5004, 32'h2, 1'b0, 1'b1);
        trace_enable = 1'b0;
        store(32'h5008, 32'h3, 1'b0, 1'b0);
        trace_enable = 1'b1;
        store(32'h500C, 32'h4, 1'b0, 1'b0);
        idle();
        check("sz_fill", fill_level, 3);
        check("sz_both", trace_size, 2'b01);
        pop_one();
        check("sz_half", trace_size, 2'b10);
        check("sz_half_seq", trace_seq, 1);
        pop_one();
        check("sz_word", trace_size, 2'b00);
        check("sz_en_addr", trace_addr, 32'h500C);
        check("sz_en_seq", trace_seq, 2);
        pop_one();

        // Reset mid-run with 3 queued entries and a store during reset
        do_reset();
        store(32'h6000, 32'hA, 1'b0, 1'b0);
        store(32'h6004, 32'hB, 1'b0, 1'b0);
        store(32'h6008, 32'hC, 1'b0, 1'b0);
        idle();
        check("mr_fill_pre", fill_level, 3);
        reset = 1'b1;
        store(32'h6100, 32'hD, 1'b0, 1'b0);
        check("mr_valid", trace_valid, 0);
        check("mr_fill",  fill_level,  0);
        check("mr_drop",  drop_count,  0);
        check("mr_addr",  trace_addr,  0);
        check("mr_data",  trace_data,  0);
        idle();
        reset = 1'b0;
        tick();
        check("mr_no_capture", fill_level, 0);
        store(32'h6200, 32'h9, 1'b0, 1'b0);
        idle();
        check("mr_next_valid", trace_valid, 1);
        check("mr_next_seq",   trace_seq,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
